muldiv_seq: RTL

- Iterative RV32M multiply/divide sequencer attached beside the execute-stage ALU.
- Accepts one M-extension operation from execute and runs a 32-step shift-add multiply or restoring divide.
- Asserts a stall to the hazard logic while busy, then presents the result for one cycle.
- Only one operation is in flight at a time; the execute stage is held until done.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  // rs1 is interpreted as signed for these ops
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as signed for these ops (MULHSU keeps rs2 unsigned)
  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring divide.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the result is registered.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div_i,
  input  logic [2*W-1:0] acc_i,   // mul: {partial, multiplier}; div: {remainder, quotient}
  input  logic [W-1:0]   opb_i,   // mul: multiplicand; div: divisor
  output logic [2*W-1:0] acc_o
);

  logic [W:0]   sum;
  logic [W:0]   sh;
  logic         ge;
  logic [W-1:0] rem_new;

  // Select one multiply step (add-then-shift-right) or one restoring divide step
  always_comb begin
    // multiply: conditionally add multiplicand to the high half, shift whole register right
    sum     = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opb_i} : {(W+1){1'b0}});
    // divide: remainder shifted left pulling in the next dividend bit
    sh      = {acc_i[2*W-1:W], acc_i[W-1]};
    ge      = (sh >= {1'b0, opb_i});
    // remainder < divisor, so the difference always fits in W bits
    rem_new = ge ? (sh[W-1:0] - opb_i) : sh[W-1:0];
    if (is_div_i) begin
      acc_o = {rem_new, acc_i[W-2:0], ge};
    end else begin
      acc_o = {sum, acc_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: 32-step shift-add multiply / restoring divide on magnitudes, then sign fix-up.
// Latency: start at cycle 0, result with DoneE in cycle 34 (cycle 1 for divide-by-zero / signed overflow).
// Backpressure: StallE holds the pipeline while busy; FlushE aborts at once; StartE ignored unless IDLE.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic [4:0]      RdE,
  input  logic            FlushE,
  output logic            StallE,
  output logic            DoneE,
  output logic [XLEN-1:0] MulDivResultE,
  output logic [4:0]      RdE_out
);

  localparam int CNT_W = $clog2(XLEN);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, step_acc;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        rd_q, rd_d;
  logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d;

  muldiv_op_e        op_in;
  logic              a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_sel;

  // Decode the incoming op and take operand magnitudes
  always_comb begin
    op_in    = muldiv_op_e'(MulDivOpE);
    a_neg    = op_a_signed(op_in) & srcAE[XLEN-1];
    b_neg    = op_b_signed(op_in) & srcBE[XLEN-1];
    a_abs    = a_neg ? -srcAE : srcAE;
    b_abs    = b_neg ? -srcBE : srcBE;
    div_zero = MulDivOpE[2] & (srcBE == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) && (srcAE == INT_MIN) && (srcBE == '1);
  end

  muldiv_step #(.W(XLEN)) u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (step_acc)
  );

  // Sign fix-up of the magnitude result and selection of the architectural result word
  always_comb begin
    prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo_fix  = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       res_sel = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_sel = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_sel = quo_fix;
      default:                      res_sel = rem_fix;
    endcase
  end

  // FSM next state and datapath register updates; a flush overrides everything but reset
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    res_d   = res_q;
    rd_d    = rd_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    if (FlushE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (StartE) begin
            op_d = op_in;
            rd_d = RdE;
            if (div_zero) begin
              // quotient all ones, remainder is the dividend
              res_d   = MulDivOpE[1] ? srcAE : '1;
              state_d = DONE;
            end else if (div_ovf) begin
              res_d   = (op_in == OP_DIV) ? INT_MIN : '0;
              state_d = DONE;
            end else begin
              a_neg_d = a_neg;
              b_neg_d = b_neg;
              acc_d   = {{XLEN{1'b0}}, (MulDivOpE[2] ? a_abs : b_abs)};
              opb_d   = MulDivOpE[2] ? b_abs : a_abs;
              cnt_d   = '0;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = step_acc;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = SIGN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SIGN: begin
          res_d   = res_sel;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
    end
  end

  // Stall covers the accepting cycle; both stall and done are killed by a flush in the same cycle
  always_comb begin
    StallE        = ~FlushE & (((state_q == IDLE) & StartE) | (state_q == CALC) | (state_q == SIGN));
    DoneE         = ~FlushE & (state_q == DONE);
    MulDivResultE = res_q;
    RdE_out       = rd_q;
  end

endmodule
